sample_acquisition_seq: RTL and testbench

//  Parametrised successor to the single-channel precharge sample sequencer. Steps through up to NUM_CH
//  az-mux/precharge-switch configurations; each step is precharge -> sample -> ADC handshake.

---
 rtl/sample_acquisition_seq.sv | 161 ++++++++++++++++
 tb/tb_sample_acquisition_seq.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/sample_acquisition_seq.sv
`default_nettype none
// ============================================================================
// Module  : sample_acquisition_seq
// Brief   : Multi-step precharge/sample/ADC-handshake sequencer driving the
//           az-mux and precharge switches for up to NUM_CH configurations.
// Revision: 1.0 - initial release
// ============================================================================
module sample_acquisition_seq #(
    parameter int                 NUM_CH   = 4,
    parameter int                 MUX_W    = 4,
    parameter int                 CNT_W    = 32,
    parameter int                 PC_W     = 24,
    parameter logic [MUX_W-1:0]   MUX_IDLE = '0,
    localparam int                c_STEP_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1,
    localparam int                c_LEN_W  = $clog2(NUM_CH) + 1
) (
    input  logic                    clk,
    input  logic                    reset_n,
    input  logic                    arm_i,
    input  logic [PC_W-1:0]         p_clk_count_precharge,
    input  logic [CNT_W-1:0]        p_clk_sample_duration,
    input  logic [c_LEN_W-1:0]      p_seq_len,
    input  logic [NUM_CH*MUX_W-1:0] p_mux_codes,
    input  logic [NUM_CH*2-1:0]     p_pc_sel,
    input  logic                    adc_done_i,
    output logic [MUX_W-1:0]        azmux_o,
    output logic                    sw_pc1_o,
    output logic                    sw_pc2_o,
    output logic                    adc_trig_o,
    output logic                    seq_done_o,
    output logic                    busy_o,
    output logic [c_STEP_W-1:0]     step_o,
    output logic [7:0]              monitor_o
);

    localparam int         c_CT_W      = (CNT_W > PC_W) ? CNT_W : PC_W;
    localparam logic [2:0] c_IDLE      = 3'd0;
    localparam logic [2:0] c_PRECHARGE = 3'd1;
    localparam logic [2:0] c_SAMPLE    = 3'd2;
    localparam logic [2:0] c_WAIT_ADC  = 3'd3;
    localparam logic [2:0] c_NEXT      = 3'd4;

    logic [2:0]          r_state;
    logic [2:0]          w_state_nxt;
    logic [c_CT_W-1:0]   r_cnt;
    logic [c_STEP_W-1:0] r_step;
    logic [MUX_W-1:0]    r_code;
    logic [1:0]          r_pc_sel;
    logic                r_adc_trig;

    logic [c_LEN_W-1:0]  w_len;
    logic                w_last;
    logic [c_STEP_W-1:0] w_next_step;
    logic [c_STEP_W-1:0] w_load_idx;
    logic [MUX_W-1:0]    w_new_code;
    logic [1:0]          w_new_sel;
    logic                w_cnt_zero;
    logic                w_start;

    // Effective length is evaluated live at the step boundary (NEXT edge).
    always_comb begin
        if (p_seq_len == '0) begin
            w_len = c_LEN_W'(1);
        end else if (p_seq_len > c_LEN_W'(NUM_CH)) begin
            w_len = c_LEN_W'(NUM_CH);
        end else begin
            w_len = p_seq_len;
        end
    end

    assign w_last      = (c_LEN_W'(r_step) >= (w_len - c_LEN_W'(1)));
    assign w_next_step = w_last ? '0 : (r_step + c_STEP_W'(1));
    assign w_load_idx  = (r_state == c_NEXT) ? w_next_step : '0;
    assign w_cnt_zero  = (r_cnt == '0);
    assign w_start     = arm_i && ((r_state == c_IDLE) || (r_state == c_NEXT));

    always_comb begin
        w_new_code = p_mux_codes[MUX_W-1:0];
        w_new_sel  = p_pc_sel[1:0];
        for (int k = 0; k < NUM_CH; k++) begin
            if (w_load_idx == k[c_STEP_W-1:0]) begin
                w_new_code = p_mux_codes[k*MUX_W +: MUX_W];
                w_new_sel  = p_pc_sel[k*2 +: 2];
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= c_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            c_IDLE:      if (arm_i) w_state_nxt = c_PRECHARGE;
            c_PRECHARGE: if (w_cnt_zero) w_state_nxt = c_SAMPLE;
            c_SAMPLE:    if (w_cnt_zero) w_state_nxt = c_WAIT_ADC;
            c_WAIT_ADC:  if (adc_done_i) w_state_nxt = c_NEXT;
            c_NEXT:      w_state_nxt = arm_i ? c_PRECHARGE : c_IDLE;
            default:     w_state_nxt = c_IDLE;
        endcase
    end

    // Step configuration is latched at step start so register writes mid-step are invisible.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_cnt      <= '0;
            r_step     <= '0;
            r_code     <= MUX_IDLE;
            r_pc_sel   <= '0;
            r_adc_trig <= 1'b0;
        end else begin
            r_adc_trig <= (r_state == c_PRECHARGE) && w_cnt_zero;
            if (w_start) begin
                r_code   <= w_new_code;
                r_pc_sel <= w_new_sel;
                r_cnt    <= c_CT_W'(p_clk_count_precharge);
            end else if (r_state == c_PRECHARGE) begin
                r_cnt <= w_cnt_zero ? c_CT_W'(p_clk_sample_duration) : (r_cnt - c_CT_W'(1));
            end else if ((r_state == c_SAMPLE) && !w_cnt_zero) begin
                r_cnt <= r_cnt - c_CT_W'(1);
            end
            if (r_state == c_IDLE) begin
                r_step <= '0;
            end else if (r_state == c_NEXT) begin
                r_step <= arm_i ? w_next_step : '0;
            end
        end
    end

    always_comb begin
        azmux_o    = MUX_IDLE;
        sw_pc1_o   = 1'b0;
        sw_pc2_o   = 1'b0;
        seq_done_o = 1'b0;
        busy_o     = (r_state != c_IDLE);
        case (r_state)
            c_PRECHARGE, c_WAIT_ADC: azmux_o = r_code;
            c_SAMPLE: begin
                azmux_o  = r_code;
                sw_pc1_o = r_pc_sel[0];
                sw_pc2_o = r_pc_sel[1];
            end
            c_NEXT: begin
                azmux_o    = r_code;
                seq_done_o = w_last;
            end
            default: azmux_o = MUX_IDLE;
        endcase
    end

    assign adc_trig_o = r_adc_trig;
    assign step_o     = r_step;
    assign monitor_o  = {r_state, adc_trig_o, sw_pc2_o, sw_pc1_o, seq_done_o, busy_o};

endmodule
`default_nettype wire

// File: tb/tb_sample_acquisition_seq.sv
`default_nettype none
// ============================================================================
// Module  : tb_sample_acquisition_seq
// Brief   : Scenario-table bench for sample_acquisition_seq with a per-cycle
//           expected-output queue built from a step timeline model.
// Revision: 1.0 - initial release
// ============================================================================
module tb_sample_acquisition_seq;

    localparam int         NUM_CH   = 4;
    localparam int         MUX_W    = 4;
    localparam int         CNT_W    = 32;
    localparam int         PC_W     = 24;
    localparam logic [3:0] MUX_IDLE = 4'h0;

    logic              clk = 1'b0;
    logic              reset_n = 1'b0;
    logic              arm_i = 1'b0;
    logic              adc_done_i = 1'b0;
    logic [PC_W-1:0]   p_clk_count_precharge = '0;
    logic [CNT_W-1:0]  p_clk_sample_duration = '0;
    logic [2:0]        p_seq_len = 3'd1;
    logic [15:0]       p_mux_codes = '0;
    logic [7:0]        p_pc_sel = '0;
    logic [3:0]        azmux_o;
    logic              sw_pc1_o, sw_pc2_o, adc_trig_o, seq_done_o, busy_o;
    logic [1:0]        step_o;
    logic [7:0]        monitor_o;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    sample_acquisition_seq #(
        .NUM_CH(NUM_CH), .MUX_W(MUX_W), .CNT_W(CNT_W), .PC_W(PC_W), .MUX_IDLE(MUX_IDLE)
    ) dut (
        .clk(clk), .reset_n(reset_n), .arm_i(arm_i),
        .p_clk_count_precharge(p_clk_count_precharge),
        .p_clk_sample_duration(p_clk_sample_duration),
        .p_seq_len(p_seq_len), .p_mux_codes(p_mux_codes), .p_pc_sel(p_pc_sel),
        .adc_done_i(adc_done_i), .azmux_o(azmux_o), .sw_pc1_o(sw_pc1_o), .sw_pc2_o(sw_pc2_o),
        .adc_trig_o(adc_trig_o), .seq_done_o(seq_done_o), .busy_o(busy_o),
        .step_o(step_o), .monitor_o(monitor_o)
    );

    // One record per observed cycle: outputs expected now, inputs to drive for the next edge.
    typedef struct {
        logic       arm, done;
        logic [2:0] len;
        logic [15:0] codes;
        logic [7:0] sel;
        logic [3:0] e_az;
        logic       e_sw1, e_sw2, e_trig, e_done, e_busy;
        logic [1:0] e_step;
    } rec_t;

    typedef struct {
        int         p, d, delay;
        bit         hold;
        logic [2:0] len_a, len_b;
        logic [15:0] codes_a, codes_b;
        logic [7:0] sel_a, sel_b;
        int         steps, chg, exp_done;
    } scen_t;

    rec_t  q[$];
    scen_t tbl[7];
    string names[7];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] outv();
        return {16'h0, azmux_o, sw_pc1_o, sw_pc2_o, adc_trig_o, seq_done_o, busy_o, step_o,
                monitor_o[4:0]};
    endfunction

    function automatic logic [31:0] expv(input rec_t r);
        return {16'h0, r.e_az, r.e_sw1, r.e_sw2, r.e_trig, r.e_done, r.e_busy, r.e_step,
                r.e_trig, r.e_sw2, r.e_sw1, r.e_done, r.e_busy};
    endfunction

    function automatic int eff_len(input logic [2:0] v);
        if (v == 3'd0) return 1;
        if (v > 3'd4) return 4;
        return int'(v);
    endfunction

    function automatic rec_t mk(input logic arm, input logic done, input logic [2:0] len,
                                input logic [15:0] codes, input logic [7:0] sel,
                                input logic [3:0] az, input logic sw1, input logic sw2,
                                input logic trig, input logic sdone, input logic busy,
                                input logic [1:0] step);
        rec_t r;
        r.arm = arm; r.done = done; r.len = len; r.codes = codes; r.sel = sel;
        r.e_az = az; r.e_sw1 = sw1; r.e_sw2 = sw2; r.e_trig = trig;
        r.e_done = sdone; r.e_busy = busy; r.e_step = step;
        return r;
    endfunction

    // Timeline model: each step is P+1 precharge, D+1 sample, delay+1 wait and one NEXT cycle.
    task automatic gen(input scen_t s);
        int          st;
        int          len_eff;
        bit          last, arm_s;
        logic [2:0]  len_in;
        logic [15:0] cin, clat;
        logic [7:0]  sin, slat;
        logic [3:0]  code;
        logic [1:0]  sel2, stp;
        st = 0;
        q.push_back(mk(1'b1, s.hold, s.len_a, s.codes_a, s.sel_a, MUX_IDLE,
                       1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0));
        for (int i = 0; i < s.steps; i++) begin
            len_in = (i >= s.chg) ? s.len_b   : s.len_a;
            cin    = (i >= s.chg) ? s.codes_b : s.codes_a;
            sin    = (i >= s.chg) ? s.sel_b   : s.sel_a;
            clat   = (i >  s.chg) ? s.codes_b : s.codes_a;
            slat   = (i >  s.chg) ? s.sel_b   : s.sel_a;
            code   = clat[st*4 +: 4];
            sel2   = slat[st*2 +: 2];
            stp    = st[1:0];
            arm_s  = (i != s.steps - 1);
            for (int k = 0; k <= s.p; k++)
                q.push_back(mk(1'b1, s.hold, len_in, cin, sin, code,
                               1'b0, 1'b0, 1'b0, 1'b0, 1'b1, stp));
            for (int k = 0; k <= s.d; k++)
                q.push_back(mk(arm_s, s.hold, len_in, cin, sin, code,
                               sel2[0], sel2[1], (k == 0), 1'b0, 1'b1, stp));
            for (int w = 0; w <= s.delay; w++)
                q.push_back(mk(arm_s, s.hold || (w == s.delay), len_in, cin, sin, code,
                               1'b0, 1'b0, 1'b0, 1'b0, 1'b1, stp));
            len_eff = eff_len(len_in);
            last    = (st >= len_eff - 1);
            q.push_back(mk(arm_s, s.hold, len_in, cin, sin, code,
                           1'b0, 1'b0, 1'b0, last, 1'b1, stp));
            st = last ? 0 : st + 1;
        end
        for (int k = 0; k < 2; k++)
            q.push_back(mk(1'b0, 1'b0, s.len_a, s.codes_a, s.sel_a, MUX_IDLE,
                           1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0));
    endtask

    task automatic run(input scen_t s, input string name);
        rec_t r;
        int   n = 0;
        int   nd = 0;
        int   nt = 0;
        p_clk_count_precharge = PC_W'(s.p);
        p_clk_sample_duration = CNT_W'(s.d);
        gen(s);
        while (q.size() != 0) begin
            r = q.pop_front();
            chk($sformatf("%s cyc%0d {az,sw1,sw2,trig,done,busy,step,mon}", name, n),
                outv(), expv(r));
            if (seq_done_o) nd++;
            if (adc_trig_o) nt++;
            arm_i       = r.arm;
            adc_done_i  = r.done;
            p_seq_len   = r.len;
            p_mux_codes = r.codes;
            p_pc_sel    = r.sel;
            n++;
            @(negedge clk);
        end
        chk({name, " seq_done count"}, nd, s.exp_done);
        chk({name, " adc_trig count"}, nt, s.steps);
    endtask

    initial begin
        //            p  d  dly hold len_a len_b codes_a  codes_b  sel_a  sel_b steps chg done
        tbl[0] = '{3, 5, 2, 1'b0, 3'd1, 3'd1, 16'h0005, 16'h0005, 8'h01, 8'h01, 3, 99, 3};
        tbl[1] = '{1, 2, 1, 1'b0, 3'd3, 3'd3, 16'h0123, 16'h0123, 8'h32, 8'h32, 7, 99, 2};
        tbl[2] = '{0, 0, 0, 1'b0, 3'd0, 3'd0, 16'h000A, 16'h000A, 8'h03, 8'h03, 2, 99, 2};
        tbl[3] = '{1, 0, 3, 1'b0, 3'd7, 3'd7, 16'h9876, 16'h9876, 8'h6D, 8'h6D, 5, 99, 1};
        tbl[4] = '{2, 1, 0, 1'b1, 3'd2, 3'd2, 16'h00C4, 16'h00C4, 8'h09, 8'h09, 3, 99, 1};
        tbl[5] = '{2, 1, 1, 1'b0, 3'd3, 3'd3, 16'h0321, 16'h0ABC, 8'h15, 8'h2A, 4, 1, 1};
        tbl[6] = '{1, 1, 0, 1'b0, 3'd4, 3'd1, 16'h4321, 16'h8765, 8'h55, 8'hFF, 4, 1, 3};
        names  = '{"len1", "len3", "p0d0len0", "len7", "donehold", "codechg", "lenshrink"};

        repeat (2) @(negedge clk);
        chk("reset outputs", outv(), 32'h0);
        reset_n = 1'b1;
        @(negedge clk);
        chk("idle after reset release", outv(), 32'h0);

        for (int i = 0; i < 7; i++) run(tbl[i], names[i]);

        // Asynchronous reset while sampling.
        p_clk_count_precharge = PC_W'(2);
        p_clk_sample_duration = CNT_W'(10);
        p_seq_len   = 3'd1;
        p_mux_codes = 16'h0007;
        p_pc_sel    = 8'h03;
        arm_i       = 1'b1;
        begin
            int waited = 0;
            while (!sw_pc1_o && waited < 40) begin
                @(negedge clk);
                waited++;
            end
            chk("reach SAMPLE {sw1,sw2,az}", {sw_pc1_o, sw_pc2_o, azmux_o}, {1'b1, 1'b1, 4'h7});
        end
        arm_i = 1'b0;
        #2 reset_n = 1'b0;
        #1 chk("async reset mid-sample", outv(), 32'h0);
        @(negedge clk);
        chk("reset held over edge", outv(), 32'h0);
        reset_n = 1'b1;
        repeat (2) @(negedge clk);
        chk("idle after mid-sample reset", outv(), 32'h0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, checks=%0d", checks);
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire
